// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
// Parses command frames arriving byte-by-byte from the UART RX deserialiser
// and hands single-cycle command beats to the TX controller.
//
// Frames (first byte is the opcode):
//   AA addr data       -> 001 / addr     / data
//   BB addr            -> 010 / addr     / 00
//   CC opA opB func    -> 011 / OPA_ADDR / opA, 011 / OPB_ADDR / opB,
//                         100 / 00       / {4'h0, func[3:0]}
//   DD func            -> 100 / 00       / {4'h0, func[3:0]}
//
// Ports:
//   RXDec_CLK          system clock
//   RXDec_RST          asynchronous active-low reset
//   RXDec_Data         received byte
//   RXDec_Data_Valid   one-cycle byte strobe
//   RXDec_Frame_Err    parity/stop error, qualified by RXDec_Data_Valid
//   RXDec_Accept       TX controller can take a beat
//   RXDec_Command      000 idle, 001 write, 010 read, 011 operand write, 100 ALU
//   RXDec_Addr         RF address of the beat
//   RXDec_Pdata        write data, or ALU function in [3:0]
//   RXDec_Frame_Drop   one-cycle pulse when a frame or byte is discarded
//   RXDec_Err_Cnt      saturating drop counter (only with RX_ERR_CNT_EN)
//
// Optional feature macro: RX_ERR_CNT_EN
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for an opcode byte
// GET_ADDR | collecting the address byte (AA / BB)
// GET_DATA | collecting the write data byte (AA)
// GET_OPA  | collecting operand A (CC)
// GET_OPB  | collecting operand B (CC)
// GET_FUNC | collecting the ALU function byte (CC / DD)
// PENDING  | frame complete, waiting for RXDec_Accept
// ISSUE    | beats going out on consecutive cycles
module rx_cmd_decoder #(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] OPA_ADDR       = 8'h00,
    parameter logic [7:0] OPB_ADDR       = 8'h01
) (
    input  logic       RXDec_CLK,
    input  logic       RXDec_RST,
    input  logic [7:0] RXDec_Data,
    input  logic       RXDec_Data_Valid,
    input  logic       RXDec_Frame_Err,
    input  logic       RXDec_Accept,
    output logic [2:0] RXDec_Command,
    output logic [7:0] RXDec_Addr,
    output logic [7:0] RXDec_Pdata,
`ifdef RX_ERR_CNT_EN
    output logic [7:0] RXDec_Err_Cnt,
`endif
    output logic       RXDec_Frame_Drop
);

    localparam int          TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, PENDING, ISSUE
    } state_t;

    typedef enum logic [1:0] {FR_WR, FR_RD, FR_OPS, FR_ALU} frame_t;

    state_t        state, state_nxt;
    frame_t        frame_q, frame_nxt;
    logic [TW-1:0] tmo_q, tmo_nxt;
    logic [1:0]    idx_q, idx_nxt, bsel, nbeats;
    logic [7:0]    addr_r, data_r, opa_r, opb_r;
    logic [3:0]    func_r;
    logic          byte_ok, in_get;
    logic [2:0]    beat_cmd, cmd_nxt;
    logic [7:0]    beat_addr, beat_data, addr_nxt, pdata_nxt;
    logic          drop_nxt;

    assign byte_ok = RXDec_Data_Valid && !RXDec_Frame_Err;
    assign in_get  = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_OPA) ||
                     (state == GET_OPB)  || (state == GET_FUNC);
    assign nbeats  = (frame_q == FR_OPS) ? 2'd3 : 2'd1;
    // The first beat is registered on the PENDING->ISSUE edge, later ones from ISSUE.
    assign bsel    = (state == PENDING) ? 2'd0 : idx_q;

    always_comb begin
        beat_cmd  = 3'b000;
        beat_addr = 8'h00;
        beat_data = 8'h00;
        case (frame_q)
            FR_WR: begin
                beat_cmd  = 3'b001;
                beat_addr = addr_r;
                beat_data = data_r;
            end
            FR_RD: begin
                beat_cmd  = 3'b010;
                beat_addr = addr_r;
            end
            FR_OPS: begin
                if (bsel == 2'd0) begin
                    beat_cmd  = 3'b011;
                    beat_addr = OPA_ADDR;
                    beat_data = opa_r;
                end else if (bsel == 2'd1) begin
                    beat_cmd  = 3'b011;
                    beat_addr = OPB_ADDR;
                    beat_data = opb_r;
                end else begin
                    beat_cmd  = 3'b100;
                    beat_data = {4'h0, func_r};
                end
            end
            default: begin
                beat_cmd  = 3'b100;
                beat_data = {4'h0, func_r};
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        frame_nxt = frame_q;
        tmo_nxt   = '0;
        idx_nxt   = idx_q;
        cmd_nxt   = 3'b000;
        addr_nxt  = 8'h00;
        pdata_nxt = 8'h00;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = 2'd0;
                if (byte_ok) begin
                    case (RXDec_Data)
                        8'hAA: begin frame_nxt = FR_WR;  state_nxt = GET_ADDR; end
                        8'hBB: begin frame_nxt = FR_RD;  state_nxt = GET_ADDR; end
                        8'hCC: begin frame_nxt = FR_OPS; state_nxt = GET_OPA;  end
                        8'hDD: begin frame_nxt = FR_ALU; state_nxt = GET_FUNC; end
                        default: ;
                    endcase
                end
            end
            GET_ADDR: if (byte_ok) state_nxt = (frame_q == FR_WR) ? GET_DATA : PENDING;
            GET_DATA: if (byte_ok) state_nxt = PENDING;
            GET_OPA:  if (byte_ok) state_nxt = GET_OPB;
            GET_OPB:  if (byte_ok) state_nxt = GET_FUNC;
            GET_FUNC: if (byte_ok) state_nxt = PENDING;
            PENDING: begin
                drop_nxt = RXDec_Data_Valid;
                if (RXDec_Accept) begin
                    state_nxt = ISSUE;
                    cmd_nxt   = beat_cmd;
                    addr_nxt  = beat_addr;
                    pdata_nxt = beat_data;
                    idx_nxt   = 2'd1;
                end
            end
            ISSUE: begin
                drop_nxt = RXDec_Data_Valid;
                if (idx_q == nbeats) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                end else begin
                    cmd_nxt   = beat_cmd;
                    addr_nxt  = beat_addr;
                    pdata_nxt = beat_data;
                    idx_nxt   = idx_q + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort paths of the collecting states; a valid byte always beats expiry.
        if (in_get) begin
            if (RXDec_Data_Valid && RXDec_Frame_Err) begin
                state_nxt = IDLE;
                drop_nxt  = 1'b1;
            end else if (!RXDec_Data_Valid) begin
                if (tmo_q == TO_LAST) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b1;
                end else begin
                    tmo_nxt = tmo_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge RXDec_CLK or negedge RXDec_RST) begin
        if (!RXDec_RST) begin
            state            <= IDLE;
            frame_q          <= FR_WR;
            tmo_q            <= '0;
            idx_q            <= 2'd0;
            RXDec_Command    <= 3'b000;
            RXDec_Addr       <= 8'h00;
            RXDec_Pdata      <= 8'h00;
            RXDec_Frame_Drop <= 1'b0;
        end else begin
            state            <= state_nxt;
            frame_q          <= frame_nxt;
            tmo_q            <= tmo_nxt;
            idx_q            <= idx_nxt;
            RXDec_Command    <= cmd_nxt;
            RXDec_Addr       <= addr_nxt;
            RXDec_Pdata      <= pdata_nxt;
            RXDec_Frame_Drop <= drop_nxt;
        end
    end

    always_ff @(posedge RXDec_CLK or negedge RXDec_RST) begin
        if (!RXDec_RST) begin
            addr_r <= 8'h00;
            data_r <= 8'h00;
            opa_r  <= 8'h00;
            opb_r  <= 8'h00;
            func_r <= 4'h0;
        end else if (byte_ok) begin
            case (state)
                GET_ADDR: addr_r <= RXDec_Data;
                GET_DATA: data_r <= RXDec_Data;
                GET_OPA:  opa_r  <= RXDec_Data;
                GET_OPB:  opb_r  <= RXDec_Data;
                GET_FUNC: func_r <= RXDec_Data[3:0];
                default: ;
            endcase
        end
    end

`ifdef RX_ERR_CNT_EN
    always_ff @(posedge RXDec_CLK or negedge RXDec_RST) begin
        if (!RXDec_RST) begin
            RXDec_Err_Cnt <= 8'h00;
        end else if (drop_nxt && (RXDec_Err_Cnt != 8'hFF)) begin
            RXDec_Err_Cnt <= RXDec_Err_Cnt + 8'h01;
        end
    end
`endif

endmodule

// File: doc/rx_cmd_decoder.md
Name: rx_cmd_decoder

Overview:
- Upstream neighbour of the TX controller in the UART command system.
- Consumes bytes from the UART RX deserialiser and parses command frames: RF write, RF read, ALU with operands, ALU without operands.
- Emits single-cycle command beats (3-bit command code, address, data) that the TX controller latches.
- Beats are issued only when the controller signals it can accept them.

Parameters:
- TIMEOUT_CYCLES, 4096: idle clock cycles allowed between bytes of one frame before the partial frame is aborted.
- OPA_ADDR, 8'h00: RF address written with operand A.
- OPB_ADDR, 8'h01: RF address written with operand B.

Ports:
- RXDec_CLK  input  1  system clock.
- RXDec_RST  input  1  asynchronous active-low reset.
- RXDec_Data  input  8  received byte.
- RXDec_Data_Valid  input  1  one-cycle strobe; RXDec_Data is valid in that cycle.
- RXDec_Frame_Err  input  1  parity/stop error flag for the byte, qualified by RXDec_Data_Valid.
- RXDec_Accept  input  1  high when the TX controller is idle and the UART TX is not busy.
- RXDec_Command  output  3  000 idle, 001 write, 010 read, 011 operand write, 100 ALU.
- RXDec_Addr  output  8  RF address for the beat.
- RXDec_Pdata  output  8  write data, or ALU function in bits [3:0] (bits [7:4] zero).
- RXDec_Frame_Drop  output  1  one-cycle pulse when a frame or byte is discarded.

Behaviour:
- Interface (already decided): one clock, RXDec_CLK; reset RXDec_RST is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-frame or mid-issue discards everything; no beat is emitted after reset.
- All outputs are registered. RXDec_Command is 000 in every cycle except issue beats.
- Frame formats (first byte is the opcode):
  - AA addr data → one beat: 001 / addr / data.
  - BB addr → one beat: 010 / addr / 00.
  - CC opA opB func → three back-to-back beats: 011 / OPA_ADDR / opA; 011 / OPB_ADDR / opB; 100 / 00 / {4'h0, func[3:0]}.
  - DD func → one beat: 100 / 00 / {4'h0, func[3:0]}.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, PENDING, ISSUE.
- IDLE: a valid byte matching an opcode moves to the first collecting state. Any other byte is ignored silently, with no drop pulse.
- Collecting states: each valid byte is stored and the FSM advances. After the last byte of the frame, go to PENDING.
- PENDING: while RXDec_Accept is 0, hold. On the cycle RXDec_Accept=1, go to ISSUE; the first beat is driven in the following cycle.
  - Minimum latency from the last byte's Data_Valid cycle to the first beat: 2 cycles.
- ISSUE: the beats of a multi-beat frame go out on consecutive cycles regardless of RXDec_Accept. Return to IDLE after the last beat.
- Timeout: the counter clears on every valid byte and counts only in GET_* states. Reaching TIMEOUT_CYCLES-1 aborts to IDLE with a Frame_Drop pulse.
- Byte with RXDec_Frame_Err=1:
  - In any GET_* state: abort to IDLE, pulse Frame_Drop.
  - In IDLE: ignored, no pulse.
- Valid byte arriving in PENDING or ISSUE: discarded, Frame_Drop pulsed. The pending frame is unaffected.
- Simultaneous Data_Valid and timeout expiry: the byte wins (counter clears, byte accepted).

Optional Feature:
- Macro RX_ERR_CNT_EN.
- Defined: adds output RXDec_Err_Cnt [7:0].
  - Increments on every Frame_Drop pulse and saturates at 8'hFF.
  - Reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Write frame: AA,05,3C with Accept=1 → exactly one beat Command=001, Addr=05, Pdata=3C, 2 cycles after the 3C strobe; no other non-zero Command.
- Read frame with backpressure: BB,07 with Accept=0 for 20 cycles, then 1 → no beat during the 20 cycles; one beat 010/07/00 the cycle after Accept rises.
- ALU with operands: CC,12,34,0A → three consecutive beats: 011/00/12, 011/01/34, 100/00/0A.
- Timeout: AA,05, then silence for TIMEOUT_CYCLES → one Frame_Drop pulse, FSM back in IDLE. A subsequent DD,03 gives beat 100/00/03.
- Errors and junk: byte 55 in IDLE → nothing. AA then a byte with Frame_Err=1 → Frame_Drop pulse, no beat. A byte arriving in PENDING → Frame_Drop pulse, and the pending beat is still correct. With RX_ERR_CNT_EN defined, RXDec_Err_Cnt=2.
- Reset: assert RXDec_RST during the second beat of a CC frame → outputs 0 immediately; no further beats after release.
